ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline registers.
//  Consumes the latched RD1/RD2 operands and the decoded op. Produces the 64-bit HI/LO result that the HI/LO write-back path uses.
//  Runs for multiple cycles and raises a stall request so the hazard logic can hold the IF/ID and ID/EX registers (EN low).
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  flush      in   1      sync abort (branch/exception clear of EX), same cycle semantics as CLR
//  start      in   1      EX holds a mul/div instruction; sampled only in IDLE
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a          in   WIDTH  RS operand (multiplicand / dividend)
//  b          in   WIDTH  RT operand (multiplier / divisor)
//  stall_req  out  1      combinational: (start & IDLE) | CALC | FIX
//  busy       out  1      registered: high in CALC and FIX
//  done       out  1      one-cycle pulse; hi/lo valid from this cycle on
//  hi         out  WIDTH  MUL: upper product; DIV: remainder
//  lo         out  WIDTH  MUL: lower product; DIV: quotient
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, hi=lo=0, done=0, busy=0, counter=0. Reset wins over flush/start.
//  - FSM states: IDLE -> CALC -> FIX -> IDLE.
//  - IDLE: on start=1 & flush=0:
//    - latch op;
//    - latch |a| and |b| (signed ops) or a and b raw;
//    - latch result-sign flags;
//    - counter=0; go to CALC.
//  - CALC: one radix-2 step per cycle.
//    - Multiply: shift-add into a 2*WIDTH accumulator.
//    - Divide: restoring shift-subtract into remainder/quotient.
//    - Counter increments each step; after WIDTH steps go to FIX.
//  - FIX: apply sign correction, write hi/lo, done=1 in the following cycle, go to IDLE.
//  - Latency: start in cycle 0 -> done high in cycle WIDTH+2 (34 for default).
//    - The stall is released in that same cycle, so EX advances exactly once.
//  - Signed MUL: 64-bit two's-complement product.
//  - Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
//  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0 (no trap).
//  - Divide by zero (both DIV/DIVU): lo=all ones, hi=a (raw dividend). Normal latency, no special state.
//  - start while busy: ignored; in-flight op unaffected.
//  - flush in CALC/FIX: next edge -> IDLE. busy=0, no done, hi/lo keep their previous values.
//  - flush and start both in IDLE: start ignored.
//  - done is never high in two consecutive cycles. hi/lo change only in the done cycle or at reset.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN:
//  - defined:
//    - MULT/MULTU compute in one cycle via the '*' operator: IDLE -> FIX -> IDLE, done in cycle 2.
//    - stall_req is high in cycle 0 only (during FIX busy=1).
//    - DIV path is unchanged.
//  - undefined: all ops use the iterative path, latency WIDTH+2.
// TESTING
//  - MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done@34, hi=0xFFFFFFFE lo=0x00000001; stall_req high cycles 0..33.
//  - MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. With MULDIV_FAST_MUL_EN: done@2.
//  - DIV a=-7 b=2 -> lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1). DIVU a=100 b=7 -> lo=14 hi=2.
//  - DIVU a=0x1234 b=0 -> done@34, lo=0xFFFFFFFF hi=0x00001234. DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  - Start MULT, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo hold prior result.
//    A new start at cycle 12 completes normally at cycle 46.
//  - rst_n=0 mid-CALC -> next cycle all outputs 0, state IDLE.
//    A start pulse during busy has no effect: a single done, for the first op's result.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_if
// Handshake/data bundle between the EX stage control and the iterative
// multiply/divide unit.
//   master : EX-stage side, drives flush/start/op/a/b and observes the result
//   slave  : the mul/div unit itself
// Signals
//   flush      abort any in-flight operation (EX clear)
//   start      EX holds a mul/div instruction (sampled only when idle)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       RS / RT operands
//   stall_req  hold request for the IF/ID and ID/EX registers
//   busy       unit is iterating or finishing
//   done       one-cycle pulse, hi/lo valid from this cycle on
//   hi, lo     product halves, or remainder / quotient
// ----------------------------------------------------------------------------
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, op, a, b,
        input  stall_req, busy, done, hi, lo
    );

    modport slave (
        input  flush, start, op, a, b,
        output stall_req, busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative radix-2 multiply/divide unit for the EX stage. Produces a
// 2*WIDTH HI/LO result for MULT, MULTU, DIV and DIVU and raises stall_req
// while it works so the front of the pipeline is held.
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   bus     ex_muldiv_if.slave (flush, start, op, a, b -> stall_req, busy,
//           done, hi, lo)
// Configuration
//   MULDIV_FAST_MUL_EN : when defined, MULT/MULTU use a single-cycle '*'
//                        and skip the iterative phase (IDLE -> FIX -> IDLE).
//                        Divides are unaffected.
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // control state (reset)
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // datapath state (no reset needed: always loaded on start)
    logic               is_div_q;
    logic               neg_q_q;   // negate product / quotient
    logic               neg_r_q;   // negate remainder
    logic [WIDTH-1:0]   mcand_q;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;     // MUL: {partial, multiplier}; DIV: {rem, quo}

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1])
            return $unsigned(-v);
        else
            return $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // operand capture
    logic             is_signed_in;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             load_start;
    logic             calc_step;

    always_comb begin
        is_signed_in = ~bus.op[0];
        sign_a       = is_signed_in & bus.a[WIDTH-1];
        sign_b       = is_signed_in & bus.b[WIDTH-1];
        mag_a        = magnitude(bus.a, is_signed_in);
        mag_b        = magnitude(bus.b, is_signed_in);
        load_start   = (state_q == S_IDLE) && bus.start && !bus.flush;
        calc_step    = (state_q == S_CALC) && !bus.flush;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
`endif

    // one radix-2 iteration
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mcand_q};
        acc_step  = acc_q;
        if (is_div_q) begin
            // restoring step: keep the difference only when it did not borrow
            if (!div_diff[WIDTH])
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // sign correction applied in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    always_comb begin
        prod_fix = neg_if2(acc_q, neg_q_q);
        if (is_div_q) begin
            hi_fix = neg_if(acc_q[2*WIDTH-1:WIDTH], neg_r_q);
            lo_fix = neg_if(acc_q[WIDTH-1:0], neg_q_q);
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    // stage: datapath registers
    always_ff @(posedge clk) begin
        if (load_start) begin
            is_div_q <= bus.op[1];
            // a zero divisor leaves quotient all ones and remainder |a|;
            // suppressing the quotient sign keeps lo all ones and hi = a
            neg_q_q  <= (sign_a ^ sign_b) & (|bus.b);
            neg_r_q  <= sign_a;
            if (bus.op[1]) begin
                mcand_q <= mag_b;
                acc_q   <= {{WIDTH{1'b0}}, mag_a};
            end else begin
                mcand_q <= mag_a;
`ifdef MULDIV_FAST_MUL_EN
                acc_q   <= fast_prod;
`else
                acc_q   <= {{WIDTH{1'b0}}, mag_b};
`endif
            end
        end else if (calc_step) begin
            acc_q <= acc_step;
        end
    end

    // stage: control FSM and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state_q <= bus.op[1] ? S_CALC : S_FIX;
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1))
                            state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!bus.flush) begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic fix_stall;
`ifdef MULDIV_FAST_MUL_EN
    // single-cycle multiplies release the stall as soon as the op is taken
    assign fix_stall = (state_q == S_FIX) && is_div_q;
`else
    assign fix_stall = (state_q == S_FIX);
`endif

    assign bus.stall_req = ((state_q == S_IDLE) && bus.start) || (state_q == S_CALC) || fix_stall;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
        return op[1] ? 34 : 2;
`else
        return 34;
`endif
    endfunction

    function automatic int exp_stalls(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
        return op[1] ? 34 : 1;
`else
        return 34;
`endif
    endfunction

    // monitor: every done must match the oldest expected result
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(bus.done), 64'(1'b0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                check({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // issue one op at the next falling edge; optionally poke a second start
    // while busy at cycle poke_at (0 = never)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_e, input logic [31:0] lo_e,
                          input string name, input int poke_at);
        int   stalls;
        logic seen;
        stalls = 0;
        seen   = 1'b0;
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb.push_back('{hi_e, lo_e, cyc + exp_lat(op), name});
        for (int i = 1; i <= 80 && !seen; i++) begin
            #1;
            if (bus.stall_req) stalls++;
            @(negedge clk);
            bus.start = (i == poke_at);
            if (i == poke_at) begin
                bus.op = 2'b11;
                bus.a  = 32'd9;
                bus.b  = 32'd3;
            end
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check({name, "_timeout"}, 64'(seen), 64'(1'b1));
        check({name, "_stall_rel"}, 64'(bus.stall_req), 64'(1'b0));
        check({name, "_stalls"}, 64'(stalls), 64'(exp_stalls(op)));
        last_hi = hi_e;
        last_lo = lo_e;
    endtask

    int c0;

    initial begin
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin", 0);
        run_op(2'b01, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, "multu_shift", 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb", 0);
        run_op(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu", 0);
        run_op(2'b11, 32'h1234,      32'd0,         32'h0000_1234, 32'hFFFF_FFFF, "divu_zero", 0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_zero", 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0);

        // flush mid-CALC, then a fresh op right after
        @(negedge clk);
        bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'(last_hi));
        check("flush_lo", 64'(bus.lo), 64'(last_lo));
        run_op(2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, "after_flush", 0);

        // flush and start together in IDLE: nothing starts
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("flush_start_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(negedge clk);

        // start while busy is ignored; only the first op completes
        run_op(2'b01, 32'h10, 32'h10, 32'h0, 32'h100, "busy_poke", 5);
        repeat (40) @(negedge clk);

        // reset mid-CALC
        @(negedge clk);
        bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_hi", 64'(bus.hi), 64'd0);
        check("rstmid_lo", 64'(bus.lo), 64'd0);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_done", 64'(bus.done), 64'd0);
        check("rstmid_stall", 64'(bus.stall_req), 64'd0);
        repeat (40) @(negedge clk);

        run_op(2'b00, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "after_rst", 0);
        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
